// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - CPU load/store unit: alignment check, sub-word read-modify-write, load formatting
module load_store_unit #(
  parameter int MEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wrdata,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [31:0] mem_rddata
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wbuf_q, wbuf_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic        misaligned, out_of_range, reject;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_fmt, store_merge;

  assign misaligned   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                        (size == 2'b10 && addr[1:0] != 2'b00);
  assign out_of_range = {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
  assign reject       = misaligned || out_of_range;

  // Lane extraction and merge both work on the word returned during RD.
  always_comb begin
    lane_b = mem_rddata[7:0];
    unique case (addr_q[1:0])
      2'd0: lane_b = mem_rddata[7:0];
      2'd1: lane_b = mem_rddata[15:8];
      2'd2: lane_b = mem_rddata[23:16];
      2'd3: lane_b = mem_rddata[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rddata[31:16] : mem_rddata[15:0];

    case (size_q)
      2'b00:   load_fmt = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_fmt = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: load_fmt = mem_rddata;
    endcase

    store_merge = mem_rddata;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0: store_merge[7:0]   = wbuf_q[7:0];
        2'd1: store_merge[15:8]  = wbuf_q[7:0];
        2'd2: store_merge[23:16] = wbuf_q[7:0];
        2'd3: store_merge[31:24] = wbuf_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      store_merge[31:16] = wbuf_q[15:0];
    end else begin
      store_merge[15:0] = wbuf_q[15:0];
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          we_d   = we;
          size_d = size;
          uns_d  = uns;
          addr_d = addr;
          wbuf_d = wdata;
          err_d  = reject;
          if (reject)                    state_d = DONE;
          else if (we && size == 2'b10)  state_d = WR;
          else                           state_d = RD;
        end
      end
      RD: begin
        if (we_q) begin
          wbuf_d  = store_merge;
          state_d = WR;
        end else begin
          rdata_d = load_fmt;
          state_d = DONE;
        end
      end
      WR:      state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wbuf_q  <= 32'h0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign err          = done & err_q;
  assign rdata        = rdata_q;
  assign mem_MemRead  = (state_q == RD);
  assign mem_MemWrite = (state_q == WR);
  assign mem_address  = (mem_MemRead || mem_MemWrite) ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wrdata   = mem_MemWrite ? wbuf_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - bench for load_store_unit: directed vectors, reset corners, random ops vs model
module tb_load_store_unit;
  localparam int MW = 64;

  logic        clk = 1'b0;
  logic        rst, req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err, mem_MemWrite, mem_MemRead;
  logic [31:0] rdata, mem_address, mem_wrdata, mem_rddata;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [MW];
  logic [31:0] ref_mem [MW];
  logic [31:0] ref_rdata;
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .err(err), .mem_address(mem_address), .mem_wrdata(mem_wrdata),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead), .mem_rddata(mem_rddata)
  );

  // Attached memory; non-read cycles return a marker so stray captures show up.
  assign mem_rddata = mem_MemRead ? mem[mem_address[7:2]] : 32'hA5A55A5A;
  always @(posedge clk) begin
    if (mem_MemWrite) mem[mem_address[7:2]] <= mem_wrdata;
    else if (pre_en)  mem[pre_idx] <= pre_val;
  end

  always @(negedge clk) begin
    tests++;
    if ((mem_MemRead && mem_MemWrite) || (err && !done) ||
        (!mem_MemRead && !mem_MemWrite && mem_address != 32'h0)) begin
      fails++;
      $display("FAIL monitor rd=%0b wr=%0b err=%0b done=%0b addr=%h (required: exclusive strobes, err only with done, addr 0 when idle)",
               mem_MemRead, mem_MemWrite, err, done, mem_address);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Spec-level model: computes outcome from the access rules with plain arithmetic.
  function automatic void model(input logic m_we, input logic [1:0] m_size, input logic m_uns,
                                input logic [31:0] m_addr, input logic [31:0] m_wdata,
                                output int e_lat, output logic e_err, output int e_rd, output int e_wr);
    logic [31:0] widx, word, mask, lane;
    int sh;
    widx  = m_addr >> 2;
    e_err = (m_size == 2'd3) || (m_size == 2'd1 && m_addr[0]) ||
            (m_size == 2'd2 && m_addr[1:0] != 2'd0) || (widx >= 32'(MW));
    if (e_err) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
      return;
    end
    word = ref_mem[widx[5:0]];
    sh   = 8 * int'(m_addr[1:0]);
    mask = (m_size == 2'd0) ? 32'hFF : (m_size == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    if (!m_we) begin
      lane = (word >> sh) & mask;
      if (!m_uns && m_size != 2'd2 && (lane & ((mask >> 1) + 32'd1)) != 32'h0) lane = lane | ~mask;
      ref_rdata = lane;
      e_lat = 2; e_rd = 1; e_wr = 0;
    end else begin
      ref_mem[widx[5:0]] = (word & ~(mask << sh)) | ((m_wdata & mask) << sh);
      e_wr  = 1;
      e_rd  = (m_size == 2'd2) ? 0 : 1;
      e_lat = (e_rd == 1) ? 3 : 2;
    end
  endfunction

  task automatic run_txn(input bit nowait, input logic t_we, input logic [1:0] t_size, input logic t_uns,
                         input logic [31:0] t_addr, input logic [31:0] t_wdata,
                         output int lat, output logic o_err, output logic [31:0] o_rdata,
                         output int nrd, output int nwr, output logic busy_bad);
    if (!nowait) @(negedge clk);
    req = 1'b1; we = t_we; size = t_size; uns = t_uns; addr = t_addr; wdata = t_wdata;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'($urandom); size = 2'($urandom); uns = 1'($urandom);
    addr = $urandom; wdata = $urandom;
    lat = -1; o_err = 1'bx; o_rdata = 32'hx; nrd = 0; nwr = 0; busy_bad = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_MemRead)  nrd++;
      if (mem_MemWrite) nwr++;
      if (!busy) busy_bad = 1'b1;
      if (done) begin
        lat = k; o_err = err; o_rdata = rdata;
        break;
      end
    end
  endtask

  task automatic apply_and_check(input string nm, input bit nowait, input logic t_we, input logic [1:0] t_size,
                                 input logic t_uns, input logic [31:0] t_addr, input logic [31:0] t_wdata);
    int e_lat, e_rd, e_wr, a_lat, a_rd, a_wr;
    logic e_err, a_err, bb;
    logic [31:0] a_rdata;
    model(t_we, t_size, t_uns, t_addr, t_wdata, e_lat, e_err, e_rd, e_wr);
    run_txn(nowait, t_we, t_size, t_uns, t_addr, t_wdata, a_lat, a_err, a_rdata, a_rd, a_wr, bb);
    check($sformatf("%s.latency", nm), 32'(a_lat), 32'(e_lat));
    check($sformatf("%s.err", nm), 32'(a_err), 32'(e_err));
    check($sformatf("%s.rdata", nm), a_rdata, ref_rdata);
    check($sformatf("%s.read_strobes", nm), 32'(a_rd), 32'(e_rd));
    check($sformatf("%s.write_strobes", nm), 32'(a_wr), 32'(e_wr));
    check($sformatf("%s.busy", nm), 32'(bb), 32'd0);
    if (t_we && !e_err)
      check($sformatf("%s.mem[%0d]", nm, t_addr >> 2), mem[t_addr[7:2]], ref_mem[t_addr[7:2]]);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          nrd;
    int          nwr;
    logic        chk;
    int          widx;
    logic [31:0] wval;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int a_lat, a_rd, a_wr, e_lat, e_rd, e_wr;
    logic a_err, bb, e_err, bad;
    logic [31:0] a_rdata, r_addr, r_wdata;
    logic [1:0] r_size;

    vecs[0]  = '{1'b0, 2'd0, 1'b0, 32'h16, 32'h0,        2, 1'b0, 32'hFFFFFF99, 1, 0, 1'b0, 0, 32'h0};
    vecs[1]  = '{1'b0, 2'd1, 1'b1, 32'h14, 32'h0,        2, 1'b0, 32'h0000AABB, 1, 0, 1'b0, 0, 32'h0};
    vecs[2]  = '{1'b0, 2'd1, 1'b0, 32'h16, 32'h0,        2, 1'b0, 32'hFFFF8899, 1, 0, 1'b0, 0, 32'h0};
    vecs[3]  = '{1'b1, 2'd0, 1'b0, 32'h15, 32'h123456CC, 3, 1'b0, 32'hFFFF8899, 1, 1, 1'b1, 5, 32'h8899CCBB};
    vecs[4]  = '{1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 2, 1'b0, 32'hFFFF8899, 0, 1, 1'b1, 8, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        2, 1'b0, 32'hDEADBEEF, 1, 0, 1'b0, 0, 32'h0};
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 32'h13, 32'h0,        1, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0, 0, 32'h0};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h22, 32'h0,        1, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0, 0, 32'h0};
    vecs[8]  = '{1'b0, 2'd3, 1'b0, 32'h20, 32'h0,        1, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0, 0, 32'h0};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h0,       1, 1'b1, 32'hDEADBEEF, 0, 0, 1'b0, 0, 32'h0};
    vecs[10] = '{1'b0, 2'd0, 1'b1, 32'h17, 32'h0,        2, 1'b0, 32'h00000088, 1, 0, 1'b0, 0, 32'h0};
    vecs[11] = '{1'b0, 2'd0, 1'b0, 32'h14, 32'h0,        2, 1'b0, 32'hFFFFFFBB, 1, 0, 1'b0, 0, 32'h0};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 32'h16, 32'hFFFF7E01, 3, 1'b0, 32'hFFFFFFBB, 1, 1, 1'b1, 5, 32'h7E01CCBB};
    vecs[13] = '{1'b1, 2'd1, 1'b0, 32'h11, 32'h5555AAAA, 1, 1'b1, 32'hFFFFFFBB, 0, 0, 1'b1, 4, 32'h0};

    // Reset with req held high; preload memory while in reset.
    rst = 1'b1; req = 1'b1; we = 1'b0; size = 2'd2; uns = 1'b0; addr = 32'h0; wdata = 32'h0;
    pre_en = 1'b0; pre_idx = 6'd0; pre_val = 32'h0;
    for (int i = 0; i < MW; i++) begin
      @(negedge clk);
      pre_en = 1'b1; pre_idx = 6'(i);
      pre_val = (i == 5) ? 32'h8899AABB : $urandom;
      ref_mem[i] = pre_val;
    end
    @(negedge clk);
    pre_en = 1'b0;
    vecs[13].wval = ref_mem[4];
    check("reset.ctrl", {27'h0, busy, done, err, mem_MemWrite, mem_MemRead}, 32'h0);
    check("reset.rdata", rdata, 32'h0);
    check("reset.mem_address", mem_address, 32'h0);
    check("reset.mem_wrdata", mem_wrdata, 32'h0);
    rst = 1'b0; req = 1'b0;
    ref_rdata = 32'h0;

    for (int i = 0; i < 14; i++) begin
      model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata, e_lat, e_err, e_rd, e_wr);
      run_txn(1'b0, vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
              a_lat, a_err, a_rdata, a_rd, a_wr, bb);
      check($sformatf("vec%0d.latency", i), 32'(a_lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d.err", i), 32'(a_err), 32'(vecs[i].err));
      check($sformatf("vec%0d.rdata", i), a_rdata, vecs[i].rdata);
      check($sformatf("vec%0d.read_strobes", i), 32'(a_rd), 32'(vecs[i].nrd));
      check($sformatf("vec%0d.write_strobes", i), 32'(a_wr), 32'(vecs[i].nwr));
      check($sformatf("vec%0d.busy", i), 32'(bb), 32'd0);
      if (vecs[i].chk) check($sformatf("vec%0d.mem", i), mem[vecs[i].widx], vecs[i].wval);
    end

    // Reset lands on the RD cycle of a halfword store.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd1; uns = 1'b0; addr = 32'hC; wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("rst_rd.in_rd", 32'(mem_MemRead), 32'd1);
    rst = 1'b1; req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h8;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (busy || done || err || mem_MemWrite || mem_MemRead || rdata != 32'h0 ||
          mem_address != 32'h0 || mem_wrdata != 32'h0) bad = 1'b1;
    end
    check("rst_rd.outputs_zero", 32'(bad), 32'd0);
    check("rst_rd.mem_unchanged", mem[3], ref_mem[3]);
    rst = 1'b0;
    ref_rdata = 32'h0;
    apply_and_check("rst_rd.next_lw", 1'b1, 1'b0, 2'd2, 1'b0, 32'hC, 32'h0);

    // Reset lands on the WR cycle of a word store: the write completes, no done follows.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'd2; uns = 1'b0; addr = 32'h24; wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check("rst_wr.in_wr", 32'(mem_MemWrite), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_wr.no_done", {30'h0, busy, done}, 32'h0);
    check("rst_wr.no_strobe", {30'h0, mem_MemWrite, mem_MemRead}, 32'h0);
    check("rst_wr.write_completed", mem[9], 32'hCAFEF00D);
    ref_mem[9] = 32'hCAFEF00D;
    rst = 1'b0;
    ref_rdata = 32'h0;
    apply_and_check("rst_wr.next_lw", 1'b1, 1'b0, 2'd2, 1'b0, 32'h24, 32'h0);

    for (int n = 0; n < 300; n++) begin
      r_size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, MW * 4 - 1));
      if ($urandom_range(0, 3) != 0) begin
        if (r_size == 2'd1) r_addr[0] = 1'b0;
        if (r_size == 2'd2) r_addr[1:0] = 2'b00;
      end
      r_wdata = $urandom;
      apply_and_check($sformatf("rand%0d", n), 1'b0, 1'($urandom), r_size, 1'($urandom), r_addr, r_wdata);
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
